// File: rtl/pwm_pkg.sv
// Shared definitions for the complementary PWM dead-time stage: FSM state
// encoding, minimum dead time and default counter width.
package pwm_pkg;

  typedef enum logic [2:0] {
    LS_ON  = 3'd0,
    DEAD_R = 3'd1,
    HS_ON  = 3'd2,
    DEAD_F = 3'd3,
    FLT    = 3'd4
  } state_t;

  localparam int DT_MIN       = 1;
  localparam int DT_W_DEFAULT = 4;

  function automatic logic is_dead(input state_t s);
    return (s == DEAD_R) || (s == DEAD_F);
  endfunction

endpackage

// File: rtl/deadtime_counter.sv
// Loadable dead-time down-counter. A load of value V starts the count at
// max(V, DT_MIN) - 1; zero flags the last cycle of the dead interval.
module deadtime_counter
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            load,
  input  logic [DT_W-1:0] load_value,
  input  logic            enable,
  output logic            zero
);

  logic [DT_W-1:0] count;

  // NOTE: no reset here on purpose; the parent asserts load during its reset,
  // which initialises the count from the current dead-time setting.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= (load_value < DT_W'(DT_MIN)) ? '0 : load_value - DT_W'(DT_MIN);
    end else if (enable && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Half-bridge gate driver: turns PWM_IN into HS_OUT/LS_OUT with programmable
// dead time. Define PWMDT_FAULT_EN to build the latched fault shutdown.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PWM_IN,
  input  logic [DT_W-1:0] DEAD,
  input  logic            FAULT,
  input  logic            FAULT_CLR,
  output logic            HS_OUT,
  output logic            LS_OUT,
  output logic            FAULTED
);

  state_t state;
  state_t state_next;
  logic   cnt_zero;
  logic   cnt_load;
  logic   cnt_en;

  // NOTE: state_next gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      LS_ON:  if (PWM_IN) state_next = DEAD_R;
      // Aborting a rising dead interval is safe: HS was never switched on.
      DEAD_R: begin
        if (!PWM_IN)       state_next = LS_ON;
        else if (cnt_zero) state_next = HS_ON;
      end
      HS_ON:  if (!PWM_IN) state_next = DEAD_F;
      DEAD_F: begin
        if (PWM_IN)        state_next = HS_ON;
        else if (cnt_zero) state_next = LS_ON;
      end
`ifdef PWMDT_FAULT_EN
      FLT:    if (!FAULT && FAULT_CLR) state_next = DEAD_F;
`endif
      default: state_next = DEAD_F;
    endcase
`ifdef PWMDT_FAULT_EN
    if (FAULT) state_next = FLT;
`endif
  end

  // Fresh count on every entry into a dead state, and during reset.
  assign cnt_load = RST || (is_dead(state_next) && (state_next != state));
  assign cnt_en   = is_dead(state);

  deadtime_counter #(.DT_W(DT_W)) u_counter (
    .clk        (CLK),
    .load       (cnt_load),
    .load_value (DEAD),
    .enable     (cnt_en),
    .zero       (cnt_zero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= DEAD_F;
      HS_OUT <= 1'b0;
      LS_OUT <= 1'b0;
    end else begin
      state  <= state_next;
      HS_OUT <= (state_next == HS_ON);
      LS_OUT <= (state_next == LS_ON);
    end
  end

`ifdef PWMDT_FAULT_EN
  always_ff @(posedge CLK) begin
    if (RST) FAULTED <= 1'b0;
    else     FAULTED <= (state_next == FLT);
  end
`else
  logic unused_fault_inputs;
  assign unused_fault_inputs = FAULT ^ FAULT_CLR;
  assign FAULTED             = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: directed literal checks plus a
// randomized run compared every cycle against a timing-based reference model.
module tb_pwm_deadtime;

  localparam int DT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pwm_in;
  logic [DT_W-1:0] dead;
  logic            fault;
  logic            fault_clr;
  logic            hs_out;
  logic            ls_out;
  logic            faulted;

  always #5 clk = ~clk;

  pwm_deadtime #(.DT_W(DT_W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .PWM_IN    (pwm_in),
    .DEAD      (dead),
    .FAULT     (fault),
    .FAULT_CLR (fault_clr),
    .HS_OUT    (hs_out),
    .LS_OUT    (ls_out),
    .FAULTED   (faulted)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: the bridge heads toward side `lvl`; the gate for that
  // side is on once `dd` edges have elapsed since edge `t0`.
  int k   = 0;
  int t0  = 0;
  int dd  = 1;
  bit lvl = 1'b0;
  bit mflt = 1'b0;

  function automatic bit settled_at(input int e);
    return (e - t0) >= dd;
  endfunction

  function automatic logic [2:0] model_out();
    bit on;
    on = settled_at(k);
    return {!mflt && lvl && on, !mflt && !lvl && on, mflt};
  endfunction

  task automatic model_step(input bit r, input bit p, input int d,
                            input bit f, input bit c);
    int dn;
    k++;
    dn = (d == 0) ? 1 : d;
    if (r) begin
      mflt = 1'b0; lvl = 1'b0; t0 = k; dd = dn;
      return;
    end
`ifdef PWMDT_FAULT_EN
    if (f) begin
      mflt = 1'b1;
      return;
    end
    if (mflt) begin
      if (c) begin
        mflt = 1'b0; lvl = 1'b0; t0 = k; dd = dn;
      end
      return;
    end
`endif
    if (p != lvl) begin
      if (settled_at(k - 1)) begin
        lvl = p; t0 = k; dd = dn;
      end else begin
        lvl = p; t0 = k - dd;
      end
    end
  endtask

  task automatic check(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: hs/ls/flt got %b expected %b", name, k, act, exp);
    end
  endtask

  task automatic tick(input bit r, input bit p, input int d,
                      input bit f, input bit c);
    rst = r; pwm_in = p; dead = DT_W'(d); fault = f; fault_clr = c;
    @(posedge clk);
    #1;
    model_step(r, p, d, f, c);
  endtask

  task automatic lit(input string name, input logic [2:0] exp);
    check(name, {hs_out, ls_out, faulted}, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model", {hs_out, ls_out, faulted}, model_out());
      check("overlap", {2'b00, hs_out & ls_out}, 3'b000);
    end
  end

  initial begin
    bit p;
    int d;
    int run;

    tick(1, 0, 3, 0, 0);
    chk_en = 1'b1;
    lit("rst_state", 3'b000);
    tick(0, 0, 3, 0, 0); lit("rst_dead1", 3'b000);
    tick(0, 0, 3, 0, 0); lit("rst_dead2", 3'b000);
    tick(0, 0, 3, 0, 0); lit("rst_ls_on", 3'b010);

    tick(0, 1, 3, 0, 0); lit("rise_ls_off", 3'b000);
    tick(0, 1, 3, 0, 0); lit("rise_dead1", 3'b000);
    tick(0, 1, 3, 0, 0); lit("rise_dead2", 3'b000);
    tick(0, 1, 3, 0, 0); lit("rise_hs_on", 3'b100);
    for (int i = 0; i < 6; i++) tick(0, 1, 3, 0, 0);
    lit("hs_hold", 3'b100);
    tick(0, 0, 3, 0, 0); lit("fall_hs_off", 3'b000);
    tick(0, 0, 3, 0, 0); lit("fall_dead1", 3'b000);
    tick(0, 0, 3, 0, 0); lit("fall_dead2", 3'b000);
    tick(0, 0, 3, 0, 0); lit("fall_ls_on", 3'b010);

    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 0); lit("dt0_rise_dead", 3'b000);
      tick(0, 1, 0, 0, 0); lit("dt0_hs_on", 3'b100);
      tick(0, 0, 0, 0, 0); lit("dt0_fall_dead", 3'b000);
      tick(0, 0, 0, 0, 0); lit("dt0_ls_on", 3'b010);
    end

    tick(0, 1, 5, 0, 0); lit("pulse_dead1", 3'b000);
    tick(0, 1, 5, 0, 0); lit("pulse_dead2", 3'b000);
    tick(0, 0, 5, 0, 0); lit("pulse_abort", 3'b010);

    for (int i = 0; i < 4; i++) tick(0, 1, 3, 0, 0);
    lit("pre_fault_hs", 3'b100);
`ifdef PWMDT_FAULT_EN
    tick(0, 1, 3, 1, 0); lit("fault_resp", 3'b001);
    tick(0, 1, 3, 1, 1); lit("clr_blocked", 3'b001);
    tick(0, 0, 3, 0, 1); lit("clr_dead0", 3'b000);
    tick(0, 0, 3, 0, 0); lit("clr_dead1", 3'b000);
    tick(0, 0, 3, 0, 0); lit("clr_dead2", 3'b000);
    tick(0, 0, 3, 0, 0); lit("clr_ls_on", 3'b010);
`else
    tick(0, 1, 3, 1, 0); lit("fault_ignored", 3'b100);
    tick(0, 1, 3, 0, 1); lit("clr_ignored", 3'b100);
    tick(0, 1, 3, 1, 1); lit("both_ignored", 3'b100);
`endif

    p = 1'b0;
    d = 3;
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        p = ~p;
        run = int'($urandom_range(1, 12));
      end
      run--;
      if ($urandom_range(0, 15) == 0) d = int'($urandom_range(0, 15));
      tick($urandom_range(0, 599) == 0, p, d,
           $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
